// File: rtl/grid_cursor_controller.sv
// Central row/column cursor for the Game of Life setup grid: press-edge moves,
// hold-to-repeat, optional edge wrap, select/toggle requests and a sticky
// in-game lockout.
module grid_cursor_controller #(
  parameter int unsigned ROWS         = 16,
  parameter int unsigned COLS         = 16,
  parameter int unsigned WRAP         = 1,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 4,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 leftButton,
  input  logic                 rightButton,
  input  logic                 upButton,
  input  logic                 downButton,
  input  logic                 selectButton,
  input  logic                 startGameSwitch,
  output logic [RW-1:0]        cursorRow,
  output logic [CW-1:0]        cursorCol,
  output logic [ROWS*COLS-1:0] redLEDs,
  output logic                 toggleValid,
  output logic [RW-1:0]        toggleRow,
  output logic [CW-1:0]        toggleCol,
  output logic                 inGame
);

  localparam int unsigned NCELL  = ROWS * COLS;
  localparam int unsigned IW     = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned CNTMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNTW   = $clog2(CNTMAX + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HELD    = 2'd1;
  localparam logic [1:0] REPEAT  = 2'd2;
  localparam logic [1:0] IN_GAME = 2'd3;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0] RATE_LAST  = CNTW'(REPEAT_RATE - 1);

  logic [1:0]       state, stateNext;
  logic [CNTW-1:0]  repeatCount, countNext;
  logic [1:0]       lastDir, lastDirNext;
  logic             prevSelect;
  logic [RW-1:0]    rowNext, rowMoved;
  logic [CW-1:0]    colNext, colMoved;
  logic [NCELL-1:0] ledNext;
  logic [IW-1:0]    cellIndex;
  logic             toggleValidNext;
  logic [RW-1:0]    toggleRowNext;
  logic [CW-1:0]    toggleColNext;
  logic             inGameNext;
  logic             dirValid;
  logic [1:0]       dirCode;
  logic             selectRise;
  logic             doMove;

  // Exactly one movement button qualifies as a direction; encode which one.
  always_comb begin
    dirValid = ((3'(leftButton) + 3'(rightButton) + 3'(upButton) + 3'(downButton)) == 3'd1);
    dirCode  = DIR_DOWN;
    if (leftButton)       dirCode = DIR_LEFT;
    else if (rightButton) dirCode = DIR_RIGHT;
    else if (upButton)    dirCode = DIR_UP;
  end

  assign selectRise = selectButton & ~prevSelect;

  // Candidate cursor position one step in the current direction, wrapping or saturating.
  always_comb begin
    rowMoved = cursorRow;
    colMoved = cursorCol;
    case (dirCode)
      DIR_LEFT:  colMoved = (cursorCol == '0) ? ((WRAP != 0) ? CW'(COLS - 1) : '0)
                                              : CW'(cursorCol - CW'(1));
      DIR_RIGHT: colMoved = (cursorCol == CW'(COLS - 1)) ? ((WRAP != 0) ? '0 : CW'(COLS - 1))
                                                         : CW'(cursorCol + CW'(1));
      DIR_UP:    rowMoved = (cursorRow == '0) ? ((WRAP != 0) ? RW'(ROWS - 1) : '0)
                                              : RW'(cursorRow - RW'(1));
      default:   rowMoved = (cursorRow == RW'(ROWS - 1)) ? ((WRAP != 0) ? '0 : RW'(ROWS - 1))
                                                         : RW'(cursorRow + RW'(1));
    endcase
  end

  // Next-state and next-output logic for the press/hold/repeat/lockout FSM.
  always_comb begin
    stateNext       = state;
    countNext       = repeatCount;
    lastDirNext     = lastDir;
    toggleValidNext = 1'b0;
    toggleRowNext   = toggleRow;
    toggleColNext   = toggleCol;
    inGameNext      = inGame;
    doMove          = 1'b0;

    if (state != IN_GAME) begin
      if (startGameSwitch) begin
        stateNext  = IN_GAME;
        inGameNext = 1'b1;
      end else begin
        toggleValidNext = selectRise;
        if (selectRise) begin
          toggleRowNext = cursorRow;
          toggleColNext = cursorCol;
        end
        case (state)
          IDLE: begin
            if (dirValid) begin
              doMove      = 1'b1;
              stateNext   = HELD;
              countNext   = '0;
              lastDirNext = dirCode;
            end
          end
          HELD, REPEAT: begin
            if (!dirValid) begin
              stateNext = IDLE;
              countNext = '0;
            end else if (dirCode != lastDir) begin
              doMove      = 1'b1;
              stateNext   = HELD;
              countNext   = '0;
              lastDirNext = dirCode;
            end else if (state == HELD) begin
              if (REPEAT_DELAY != 0) begin
                if (repeatCount == DELAY_LAST) begin
                  doMove    = 1'b1;
                  stateNext = REPEAT;
                  countNext = '0;
                end else begin
                  countNext = CNTW'(repeatCount + CNTW'(1));
                end
              end
            end else begin
              if (repeatCount == RATE_LAST) begin
                doMove    = 1'b1;
                countNext = '0;
              end else begin
                countNext = CNTW'(repeatCount + CNTW'(1));
              end
            end
          end
          default: ;
        endcase
      end
    end

    rowNext   = doMove ? rowMoved : cursorRow;
    colNext   = doMove ? colMoved : cursorCol;
    cellIndex = IW'(IW'(rowNext) * IW'(COLS) + IW'(colNext));
    ledNext   = inGameNext ? '0 : (NCELL'(1) << cellIndex);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      repeatCount <= '0;
      lastDir     <= DIR_LEFT;
      prevSelect  <= 1'b0;
      cursorRow   <= '0;
      cursorCol   <= '0;
      redLEDs     <= NCELL'(1);
      toggleValid <= 1'b0;
      toggleRow   <= '0;
      toggleCol   <= '0;
      inGame      <= 1'b0;
    end else begin
      state       <= stateNext;
      repeatCount <= countNext;
      lastDir     <= lastDirNext;
      prevSelect  <= selectButton;
      cursorRow   <= rowNext;
      cursorCol   <= colNext;
      redLEDs     <= ledNext;
      toggleValid <= toggleValidNext;
      toggleRow   <= toggleRowNext;
      toggleCol   <= toggleColNext;
      inGame      <= inGameNext;
    end
  end

endmodule

// File: tb/tb_grid_cursor_controller.sv
// Scoreboard bench: a wrapping and a saturating instance share stimulus and are
// checked every cycle against a hold-length based reference model.
module tb_grid_cursor_controller;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int RR = 2;

  typedef struct packed {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [15:0] leds;
    logic        tv;
    logic [1:0]  trow;
    logic [1:0]  tcol;
    logic        ig;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic leftButton = 1'b0, rightButton = 1'b0, upButton = 1'b0, downButton = 1'b0;
  logic selectButton = 1'b0, startGameSwitch = 1'b0;

  logic [1:0]  rowW, colW, trowW, tcolW, rowS, colS, trowS, tcolS;
  logic [15:0] ledsW, ledsS;
  logic        tvW, igW, tvS, igS;

  always #5 clk = ~clk;

  grid_cursor_controller #(.ROWS(N), .COLS(N), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dutWrap (
    .clk(clk), .reset(reset), .leftButton(leftButton), .rightButton(rightButton),
    .upButton(upButton), .downButton(downButton), .selectButton(selectButton),
    .startGameSwitch(startGameSwitch), .cursorRow(rowW), .cursorCol(colW), .redLEDs(ledsW),
    .toggleValid(tvW), .toggleRow(trowW), .toggleCol(tcolW), .inGame(igW));

  grid_cursor_controller #(.ROWS(N), .COLS(N), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dutSat (
    .clk(clk), .reset(reset), .leftButton(leftButton), .rightButton(rightButton),
    .upButton(upButton), .downButton(downButton), .selectButton(selectButton),
    .startGameSwitch(startGameSwitch), .cursorRow(rowS), .cursorCol(colS), .redLEDs(ledsS),
    .toggleValid(tvS), .toggleRow(trowS), .toggleCol(tcolS), .inGame(igS));

  exp_t qW[$];
  exp_t qS[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  // Reference model state; index 0 = wrapping instance, 1 = saturating instance.
  int mRow[2], mCol[2], mTr[2], mTc[2];
  int holdDir = -1, holdLen = 0;
  bit prevSel = 1'b0, mInGame = 1'b0, mTv = 1'b0;

  function automatic int stepPos(input int p, input int delta, input bit wrap);
    int q;
    q = p + delta;
    if (q < 0)  q = wrap ? N - 1 : 0;
    if (q >= N) q = wrap ? 0 : N - 1;
    return q;
  endfunction

  function automatic exp_t expected(input int w);
    exp_t e;
    logic [15:0] one;
    one    = 16'h0001;
    e.row  = 2'(mRow[w]);
    e.col  = 2'(mCol[w]);
    e.leds = mInGame ? 16'h0000 : (one << (mRow[w] * N + mCol[w]));
    e.tv   = mTv;
    e.trow = 2'(mTr[w]);
    e.tcol = 2'(mTc[w]);
    e.ig   = mInGame;
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model to the following edge, queue expectations.
  task automatic step(input bit l, input bit r, input bit u, input bit d,
                      input bit s, input bit st, input bit rs);
    int  n, dir;
    bit  selRise, mv;
    @(negedge clk);
    leftButton = l; rightButton = r; upButton = u; downButton = d;
    selectButton = s; startGameSwitch = st; reset = rs;
    if (rs) begin
      holdDir = -1; holdLen = 0; prevSel = 1'b0; mInGame = 1'b0; mTv = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mRow[w] = 0; mCol[w] = 0; mTr[w] = 0; mTc[w] = 0;
      end
    end else begin
      selRise = s && !prevSel;
      prevSel = s;
      mTv = 1'b0;
      if (!mInGame && st) begin
        mInGame = 1'b1;
      end else if (!mInGame) begin
        n   = int'(l) + int'(r) + int'(u) + int'(d);
        dir = (n != 1) ? -1 : (l ? 0 : (r ? 1 : (u ? 2 : 3)));
        if (dir < 0) holdLen = 0;
        else if (holdLen > 0 && dir == holdDir) holdLen++;
        else holdLen = 1;
        holdDir = dir;
        mv = (dir >= 0) && (holdLen == 1 ||
             (RD > 0 && holdLen > RD && ((holdLen - RD - 1) % RR) == 0));
        mTv = selRise;
        for (int w = 0; w < 2; w++) begin
          if (selRise) begin
            mTr[w] = mRow[w];
            mTc[w] = mCol[w];
          end
          if (mv) begin
            case (dir)
              0:       mCol[w] = stepPos(mCol[w], -1, w == 0);
              1:       mCol[w] = stepPos(mCol[w], 1, w == 0);
              2:       mRow[w] = stepPos(mRow[w], -1, w == 0);
              default: mRow[w] = stepPos(mRow[w], 1, w == 0);
            endcase
          end
        end
      end
    end
    qW.push_back(expected(0));
    qS.push_back(expected(1));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Stimulus: directed scenarios followed by randomized button activity.
  initial begin
    bit [3:0] btn;
    bit       sel, st, rs;
    btn = '0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 4; i++) begin step(0, 1, 0, 0, 0, 0, 0); idle(2); end
    for (int i = 0; i < 4; i++) begin step(1, 0, 0, 0, 0, 0, 0); idle(2); end

    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0);
    idle(4);

    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0); idle(1);
    step(0, 0, 0, 1, 0, 0, 0); idle(1);
    step(0, 1, 0, 0, 0, 0, 0); idle(1);
    step(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 1, 0, 0);
    idle(2);

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0); idle(1);
    step(1, 0, 0, 0, 0, 0, 0); idle(1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1, 0); idle(1);
    step(0, 1, 0, 0, 1, 1, 0); idle(1);
    step(0, 0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 1, 0, 0); idle(2);

    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0, 1:    btn = 4'(1 << $urandom_range(3));
          2:       btn = 4'h0;
          default: btn = 4'($urandom_range(15));
        endcase
      end
      sel = ($urandom_range(2) == 0);
      st  = ($urandom_range(99) == 0);
      rs  = ($urandom_range(59) == 0);
      step(btn[0], btn[1], btn[2], btn[3], sel, st, rs);
    end
    idle(1);
    done = 1'b1;
  end

  // Monitor: after each edge, pop expectations and compare against both instances.
  initial begin
    exp_t e, a;
    int   budget;
    budget = 0;
    forever begin
      @(posedge clk);
      #1;
      budget++;
      if (qW.size() > 0) begin
        e = qW.pop_front();
        a = '{rowW, colW, ledsW, tvW, trowW, tcolW, igW};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL wrap t=%0t got row=%0d col=%0d leds=%h tv=%b trow=%0d tcol=%0d ig=%b required row=%0d col=%0d leds=%h tv=%b trow=%0d tcol=%0d ig=%b",
                   $time, a.row, a.col, a.leds, a.tv, a.trow, a.tcol, a.ig,
                   e.row, e.col, e.leds, e.tv, e.trow, e.tcol, e.ig);
        end
      end
      if (qS.size() > 0) begin
        e = qS.pop_front();
        a = '{rowS, colS, ledsS, tvS, trowS, tcolS, igS};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL sat t=%0t got row=%0d col=%0d leds=%h tv=%b trow=%0d tcol=%0d ig=%b required row=%0d col=%0d leds=%h tv=%b trow=%0d tcol=%0d ig=%b",
                   $time, a.row, a.col, a.leds, a.tv, a.trow, a.tcol, a.ig,
                   e.row, e.col, e.leds, e.tv, e.trow, e.tcol, e.ig);
        end
      end
      if (done && qW.size() == 0 && qS.size() == 0) break;
      if (budget > 20000) begin
        errors++;
        $display("FAIL timeout got budget=%0d required drained queues", budget);
        break;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
